// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and the
// default bit period used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS              = 8;
    localparam int DEFAULT_CLOCKS_PER_BIT = 139;   // 16 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop handshake, full/empty flags and occupancy
// count. A push while full succeeds only if a pop happens in the same cycle;
// a pop while empty is ignored. Head entry is shown combinationally and reads
// as zero when empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_pop;
    logic                  do_push;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_FULL);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign count     = count_reg;
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a byte FIFO drained through a ready/valid port.
// rx is double-flopped, a start edge is confirmed at half a bit period, and
// every later bit is sampled one full period apart (mid-bit). Bad stop bits
// raise a sticky frame_error and park the FSM until the line returns high.
// Optional build macro UART_RX_PARITY_EN adds a parity bit after the data
// bits, the parity_odd input and the sticky parity_error output.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = DEFAULT_CLOCKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 3
)(
    input  logic                      clock_input,
    input  logic                      reset,
    input  logic                      rx,
    output logic [DATA_BITS-1:0]      data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [FIFO_DEPTH_LOG2:0]  fifo_count,
    output logic                      overflow,
    output logic                      frame_error,
`ifdef UART_RX_PARITY_EN
    input  logic                      parity_odd,
    output logic                      parity_error,
`endif
    input  logic                      clear_errors
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLOCKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rx_s;
    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 expire;
    logic                 last_bit;
    logic                 push;
    logic                 frame_evt;
    logic                 overflow_evt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overflow_reg;
    logic                 frame_error_reg;
`ifdef UART_RX_PARITY_EN
    logic                 parity_expected;
    logic                 parity_bad_reg;
    logic                 parity_evt;
    logic                 parity_error_reg;
`endif

    // Counter reaching one marks the sample point for the current bit.
    assign expire   = (cnt_reg == CNT_ONE);
    assign last_bit = (bit_idx_reg == IDX_LAST);
    assign rx_s     = sync_reg[1];

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit equals the XOR of the data; odd inverts it.
    assign parity_expected = (^shift_reg) ^ parity_odd;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    // FSM state register.
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (expire) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (expire && last_bit) state_next = PARITY;
            PARITY:  if (expire) state_next = STOP;
`else
            DATA:    if (expire && last_bit) state_next = STOP;
`endif
            STOP:    if (expire) state_next = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: FIFO push and error events, all decided at the stop/parity sample.
    always_comb begin
        push      = 1'b0;
        frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_evt = 1'b0;
`endif
        case (state_reg)
            STOP: begin
                if (expire) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push = !parity_bad_reg;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expire && (rx_s != parity_expected)) begin
                    parity_evt = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE:    cnt_reg <= HALF_BIT;
                BREAK:   ;
                default: cnt_reg <= expire ? FULL_BIT : (cnt_reg - CNT_ONE);
            endcase
            if (state_reg == START) begin
                bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_reg <= 1'b0;
`endif
            end
            if ((state_reg == DATA) && expire) begin
                shift_reg   <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_idx_reg <= bit_idx_reg + IDX_ONE;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_evt) begin
                parity_bad_reg <= 1'b1;
            end
`endif
        end
    end

    // A push into a full FIFO is lost unless the consumer pops in the same cycle.
    assign overflow_evt = push && fifo_full && !(data_ready && data_valid);

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            overflow_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_reg <= 1'b0;
`endif
        end else begin
            if (overflow_evt) begin
                overflow_reg <= 1'b1;
            end else if (clear_errors) begin
                overflow_reg <= 1'b0;
            end
            if (frame_evt) begin
                frame_error_reg <= 1'b1;
            end else if (clear_errors) begin
                frame_error_reg <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (parity_evt) begin
                parity_error_reg <= 1'b1;
            end else if (clear_errors) begin
                parity_error_reg <= 1'b0;
            end
`endif
        end
    end

    assign overflow    = overflow_reg;
    assign frame_error = frame_error_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_reg;
`endif
    assign data_valid  = !fifo_empty;

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clock_input),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (data_ready),
        .head_data (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered at CLOCKS_PER_BIT=8, depth 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_buffered;

    localparam int CPB   = 8;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic           clock_input = 1'b0;
    logic           reset       = 1'b1;
    logic           rx          = 1'b1;
    logic           data_ready  = 1'b0;
    logic           clear_errors = 1'b0;
    logic [7:0]     data_out;
    logic           data_valid;
    logic [DL2:0]   fifo_count;
    logic           overflow;
    logic           frame_error;
`ifdef UART_RX_PARITY_EN
    logic           parity_odd = 1'b0;
    logic           parity_error;
`endif

    int total = 0;
    int bad   = 0;
    int rise_at;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         pops;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] model_q [$];
    logic       model_ovf;
    logic       model_ferr;

    always #5 clock_input = ~clock_input;

    uart_rx_buffered #(
        .CLOCKS_PER_BIT  (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clock_input  (clock_input),
        .reset        (reset),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .frame_error  (frame_error),
`ifdef UART_RX_PARITY_EN
        .parity_odd   (parity_odd),
        .parity_error (parity_error),
`endif
        .clear_errors (clear_errors)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One 8N1 frame; data_ready is pulsed for the single cycle ending at
    // falling-edge index pulse_at (index 0 = edge where the start bit begins).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int pulse_at);
        logic [9:0] bits;
        int         cyc;
        logic       prev;
        bits    = {stop_bit, d, 1'b0};
        cyc     = 0;
        rise_at = -1;
        prev    = data_valid;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clock_input);
                cyc++;
                data_ready = (cyc == pulse_at);
                if (!prev && data_valid && rise_at < 0) rise_at = cyc;
                prev = data_valid;
            end
        end
        data_ready = 1'b0;
    endtask

    task automatic line_level(input logic v, input int nbits);
        rx = v;
        repeat (nbits * CPB) @(negedge clock_input);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, " valid"}, data_valid, 1);
        check(name, data_out, exp);
        data_ready = 1'b1;
        @(negedge clock_input);
        data_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clock_input);
        clear_errors = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       ok;
        int         np;
        logic [9:0] part;

        vecs[0] = '{8'hA5, 1'b1, 0, 1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 0, 2, 8'hA5, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 0, 2, 8'hA5, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1, 2, 8'h3C, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1, 2, 8'h00, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 2, 1, 8'h7E, 1'b1};

        // Reset state
        repeat (3) @(negedge clock_input);
        check("rst count", fifo_count, 0);
        check("rst valid", data_valid, 0);
        check("rst data", data_out, 0);
        check("rst overflow", overflow, 0);
        check("rst frame_error", frame_error, 0);
        reset = 1'b0;
        line_level(1'b1, 1);

        // Single frame with push latency
        send_frame(8'hA5, 1'b1, -1);
        check_range("a5 valid rise cycle", rise_at, 78, 80);
        check("a5 count", fifo_count, 1);
        pop_check("a5 data", 8'hA5);
        check("a5 count after pop", fifo_count, 0);
        check("a5 valid after pop", data_valid, 0);

        // Glitch: two clocks low must not start a frame
        rx = 1'b0;
        repeat (2) @(negedge clock_input);
        line_level(1'b1, 3);
        check("glitch count", fifo_count, 0);
        check("glitch frame_error", frame_error, 0);
        check("glitch overflow", overflow, 0);
        send_frame(8'h5A, 1'b1, -1);
        pop_check("post-glitch data", 8'h5A);

        // Table-driven frames with interleaved pops
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, -1);
            if (!vecs[i].stop_ok) begin
                line_level(1'b0, 1);
                line_level(1'b1, 1);
            end
            for (int p = 0; p < vecs[i].pops; p++) begin
                data_ready = 1'b1;
                @(negedge clock_input);
                data_ready = 1'b0;
            end
            check($sformatf("vec%0d count", i), fifo_count, vecs[i].exp_count);
            check($sformatf("vec%0d head", i), data_out, vecs[i].exp_head);
            check($sformatf("vec%0d frame_error", i), frame_error, vecs[i].exp_ferr);
            check($sformatf("vec%0d overflow", i), overflow, 0);
        end
        pulse_clear();
        check("vec clear frame_error", frame_error, 0);
        pop_check("vec drain", 8'h7E);
        check("vec drained count", fifo_count, 0);

        // Overflow: nine bytes, no consumer
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, -1);
        check("ovf count", fifo_count, 8);
        check("ovf flag", overflow, 1);
        check("ovf head", data_out, 8'h00);
        pulse_clear();
        check("ovf cleared", overflow, 0);

        // Full FIFO, pop in the push cycle of a new byte
        send_frame(8'hEE, 1'b1, 78);
        check("full+pop overflow", overflow, 0);
        check("full+pop count", fifo_count, 8);
        for (int i = 1; i < 8; i++) pop_check($sformatf("full+pop out%0d", i), 8'(i));
        pop_check("full+pop last", 8'hEE);
        check("full+pop drained", fifo_count, 0);

        // Framing error, held-low line, then a clean byte
        send_frame(8'h3C, 1'b0, -1);
        line_level(1'b0, 3);
        line_level(1'b1, 1);
        send_frame(8'h55, 1'b1, -1);
        check("frm frame_error", frame_error, 1);
        check("frm count", fifo_count, 1);
        pop_check("frm data", 8'h55);
        pulse_clear();
        check("frm cleared", frame_error, 0);

        // Randomized traffic against a queue model
        model_q.delete();
        model_ovf  = 1'b0;
        model_ferr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, -1);
            if (ok) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else model_ovf = 1'b1;
            end else begin
                model_ferr = 1'b1;
                line_level(1'b0, $urandom_range(0, 2));
                line_level(1'b1, 1);
            end
            np = $urandom_range(0, 1);
            for (int p = 0; p < np; p++) begin
                if (model_q.size() > 0) begin
                    check($sformatf("rnd%0d pop", n), data_out, model_q.pop_front());
                end
                data_ready = 1'b1;
                @(negedge clock_input);
                data_ready = 1'b0;
            end
            check($sformatf("rnd%0d count", n), fifo_count, model_q.size());
            check($sformatf("rnd%0d overflow", n), overflow, model_ovf);
            check($sformatf("rnd%0d frame_error", n), frame_error, model_ferr);
            if ($urandom_range(0, 9) == 0) begin
                pulse_clear();
                model_ovf  = 1'b0;
                model_ferr = 1'b0;
            end
        end
        while (model_q.size() > 0) pop_check("rnd drain", model_q.pop_front());
        check("rnd drained count", fifo_count, 0);

        // Async reset in the middle of a frame with bytes queued
        send_frame(8'h12, 1'b0, -1);
        line_level(1'b1, 1);
        send_frame(8'h34, 1'b1, -1);
        send_frame(8'h56, 1'b1, -1);
        check("mid pre count", fifo_count, 2);
        check("mid pre frame_error", frame_error, 1);
        part = {1'b1, 8'hF0, 1'b0};
        for (int b = 0; b < 5; b++) line_level(part[b], 1);
        rx = part[5];
        repeat (CPB / 2) @(negedge clock_input);
        #2 reset = 1'b1;
        #1;
        check("mid rst count", fifo_count, 0);
        check("mid rst valid", data_valid, 0);
        check("mid rst data", data_out, 0);
        check("mid rst overflow", overflow, 0);
        check("mid rst frame_error", frame_error, 0);
        rx = 1'b1;
        @(negedge clock_input);
        reset = 1'b0;
        line_level(1'b1, 2);
        send_frame(8'h81, 1'b1, -1);
        check("post rst count", fifo_count, 1);
        check("post rst frame_error", frame_error, 0);
        pop_check("post rst data", 8'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
